// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: shared constants, tap indices and FSM state type for the window generator
package conv_window_gen_pkg;
  localparam int PIX_W    = 20;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = WIN_TAPS * PIX_W;
  // tap k = (dr+1)*3 + (dc+1), k*PIX_W is the bit offset in the window word
  localparam int TAP_TL = 0;
  localparam int TAP_TM = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BM = 7;
  localparam int TAP_BR = 8;
  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: frame control, pixel input and window output bundle
//   slave  (generator side): i_start, i_valid, i_pix in; o_ready, o_valid, o_data, o_busy, o_done out
//   master (source/sink side): the reverse
//   CONV_WGEN_WIN_CNT_EN adds o_win_cnt (CNT_W bits, generator output)
interface conv_window_gen_if #(
  parameter int PIX_W = 20,
  parameter int CNT_W = 13
);
  logic                                        i_start;
  logic                                        i_valid;
  logic [PIX_W-1:0]                            i_pix;
  logic                                        o_ready;
  logic                                        o_valid;
  logic [conv_window_gen_pkg::WIN_TAPS*PIX_W-1:0] o_data;
  logic                                        o_busy;
  logic                                        o_done;
`ifdef CONV_WGEN_WIN_CNT_EN
  logic [CNT_W-1:0]                            o_win_cnt;
  modport slave  (input i_start, i_valid, i_pix, output o_ready, o_valid, o_data, o_busy, o_done, o_win_cnt);
  modport master (output i_start, i_valid, i_pix, input o_ready, o_valid, o_data, o_busy, o_done, o_win_cnt);
`else
  modport slave  (input i_start, i_valid, i_pix, output o_ready, o_valid, o_data, o_busy, o_done);
  modport master (output i_start, i_valid, i_pix, input o_ready, o_valid, o_data, o_busy, o_done);
`endif
endinterface

// File: rtl/conv_window_gen_pix_shift_chain.sv
// pix_shift_chain: DEPTH-entry pixel shift register exposing the nine 3x3 taps
//   clk, reset (async active-low), en (shift), din (pixel into entry 0), taps (flat 9-tap bus)
//   Taps are taken from the post-shift view so the caller can register a window
//   in the same cycle the pixel shifts in.
module pix_shift_chain #(
  parameter int DEPTH = 131,
  parameter int PIX_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PIX_W-1:0]   din,
  output logic [9*PIX_W-1:0] taps
);
  localparam int W = (DEPTH - 3) / 2;
  logic [DEPTH-1:0][PIX_W-1:0] sr, nxt;
  assign nxt = en ? {sr[DEPTH-2:0], din} : sr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sr <= '0;
    else sr <= nxt;
  for (genvar k = 0; k < 9; k++) begin : g_tap
    assign taps[k*PIX_W +: PIX_W] = nxt[(2 - k / 3) * W + (2 - k % 3)];
  end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to zero-padded 3x3 windows, one per pixel
//   clk, reset (async active-low), s (conv_window_gen_if.slave): start/done frame control,
//   i_valid/i_pix/o_ready pixel input, o_valid/o_data window output, o_busy.
//   CONV_WGEN_WIN_CNT_EN adds s.o_win_cnt, the number of windows emitted this frame.
module conv_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = conv_window_gen_pkg::PIX_W
) (
  input logic             clk,
  input logic             reset,
  conv_window_gen_if.slave s
);
  import conv_window_gen_pkg::*;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int IW   = $clog2(NPIX + 1);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  state_t                     state, nxt_state;
  logic [IW-1:0]              in_cnt;
  logic [RW-1:0]              out_r;
  logic [CW-1:0]              out_c;
  logic                       acc, shift, emit, start, last_row, last_col;
  logic [WIN_TAPS*PIX_W-1:0]  taps, win, data_q;
  logic                       valid_q, done_q;
  assign start     = state == IDLE && s.i_start;
  assign s.o_ready = state == FILL || state == RUN;
  assign acc       = s.i_valid && s.o_ready;
  assign shift     = acc || state == DRAIN;
  // the first W+1 pixels only prime the chain; every later accept and every drain cycle emits
  assign emit      = (acc && state == RUN) || state == DRAIN;
  assign last_row  = out_r == RW'(IMG_H - 1);
  assign last_col  = out_c == CW'(IMG_W - 1);
  pix_shift_chain #(.DEPTH(2 * IMG_W + 3), .PIX_W(PIX_W)) u_chain (
    .clk  (clk),
    .reset(reset),
    .en   (shift),
    .din  (state == DRAIN ? '0 : s.i_pix),
    .taps (taps)
  );
  for (genvar k = 0; k < WIN_TAPS; k++) begin : g_mask
    assign win[k*PIX_W +: PIX_W] =
      ((k inside {TAP_TL, TAP_TM, TAP_TR} && out_r == '0) ||
       (k inside {TAP_BL, TAP_BM, TAP_BR} && last_row) ||
       (k inside {TAP_TL, TAP_ML, TAP_BL} && out_c == '0) ||
       (k inside {TAP_TR, TAP_MR, TAP_BR} && last_col)) ? '0 : taps[k*PIX_W +: PIX_W];
  end
  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    nxt_state = s.i_start ? FILL : IDLE;
      FILL:    nxt_state = (acc && in_cnt == IW'(IMG_W)) ? RUN : FILL;
      RUN:     nxt_state = (acc && in_cnt == IW'(NPIX - 1)) ? DRAIN : RUN;
      DRAIN:   nxt_state = (last_row && last_col) ? DONE : DRAIN;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_r   <= '0;
      out_c   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= nxt_state;
      valid_q <= emit;
      // DONE is the cycle the last window is on o_data; o_done follows it
      done_q  <= state == DONE;
      if (emit) data_q <= win;
      if (start) begin
        in_cnt <= '0;
        out_r  <= '0;
        out_c  <= '0;
      end else begin
        if (acc) in_cnt <= in_cnt + 1'b1;
        if (emit) begin
          out_c <= last_col ? '0 : out_c + 1'b1;
          if (last_col) out_r <= out_r + 1'b1;
        end
      end
    end
  assign s.o_valid = valid_q;
  assign s.o_data  = data_q;
  assign s.o_done  = done_q;
  assign s.o_busy  = state != IDLE;
`ifdef CONV_WGEN_WIN_CNT_EN
  logic [IW-1:0] win_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) win_cnt <= '0;
    else if (start) win_cnt <= '0;
    else if (emit) win_cnt <= win_cnt + 1'b1;
  assign s.o_win_cnt = win_cnt;
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen on a 4x4 image of pixels 1..16
module tb_conv_window_gen;
  localparam int W = 4;
  localparam int H = 4;
  localparam int PW = 20;
  localparam int DW = 9 * PW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int frame_wins = 0;
  logic prev_valid = 1'b0;
  logic [DW-1:0] first_win = '0, last_win = '0;
  logic [DW-1:0] exp_q[$];
  conv_window_gen_if #(.PIX_W(PW), .CNT_W($clog2(W * H + 1))) bus ();
  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .s    (bus)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] px_at(input int r, input int c);
    return (r < 0 || r >= H || c < 0 || c >= W) ? '0 : PW'(r * W + c + 1);
  endfunction

  function automatic logic [DW-1:0] model(input int r, input int c);
    logic [DW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = px_at(r + k / 3 - 1, c + k % 3 - 1);
    return w;
  endfunction

  // taps listed TL..BR
  function automatic logic [DW-1:0] pack(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    int v[9];
    logic [DW-1:0] w;
    v = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
    return w;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (bus.o_valid) begin
        if (frame_wins == 0) first_win = bus.o_data;
        last_win = bus.o_data;
        frame_wins++;
        if (exp_q.size() == 0) check("unexpected_window", bus.o_data, '1);
        else check("window", bus.o_data, exp_q.pop_front());
      end
      if (bus.o_done) begin
        check("done_after_last", {prev_valid, exp_q.size() == 0}, 2'b11);
`ifdef CONV_WGEN_WIN_CNT_EN
        check("win_cnt_at_done", bus.o_win_cnt, 16);
`endif
      end
    end
    prev_valid = bus.o_valid;
  end

  task automatic send(input logic [PW-1:0] px);
    int t = 0;
    bus.i_valid = 1'b1;
    bus.i_pix = px;
    while (!bus.o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) check("ready_timeout", 0, 1);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic begin_frame();
    frame_wins = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(model(r, c));
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic run_frame(input int maxgap, input bit mid_start);
    int t = 0;
    begin_frame();
    for (int n = 0; n < W * H; n++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      if (mid_start && n == 8) begin
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
      end
      send(PW'(n + 1));
    end
    for (int i = 0; i < W + 1; i++) begin
      check("drain_ready_low", bus.o_ready, 0);
      @(negedge clk);
    end
    while (!bus.o_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", bus.o_done, 1);
    check("window_count", frame_wins, 16);
    check("first_window", first_win, pack(0, 0, 0, 0, 1, 2, 0, 5, 6));
    check("last_window", last_win, pack(11, 12, 0, 15, 16, 0, 0, 0, 0));
    @(negedge clk);
    check("done_one_cycle", bus.o_done, 0);
    check("idle_not_busy", bus.o_busy, 0);
  endtask

  initial begin
    bus.i_start = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_pix = 20'hABCDE;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_ready", bus.o_ready, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_data", bus.o_data, 0);
`ifdef CONV_WGEN_WIN_CNT_EN
    check("rst_win_cnt", bus.o_win_cnt, 0);
`endif
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_pix = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b0);
    run_frame(3, 1'b1);
    begin_frame();
    check("busy_after_start", bus.o_busy, 1);
    for (int n = 0; n < 9; n++) send(PW'(n + 1));
    #2 reset = 1'b0;
    #1;
    check("midrun_rst_valid", bus.o_valid, 0);
    check("midrun_rst_ready", bus.o_ready, 0);
    check("midrun_rst_busy", bus.o_busy, 0);
    check("midrun_rst_data", bus.o_data, 0);
    check("midrun_windows", frame_wins, 4);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
